conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buffer.sv | 43 ++++
 rtl/conv3x3_stream.sv | 222 ++++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv3x3_stream slice: FSM state encoding,
// kernel coefficient type and the SobelX reset kernel.
package conv_pkg;
    localparam int KW = 8;

    typedef logic signed [KW-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    // Row-major {-1,0,1; -2,0,2; -1,0,1}
    localparam coef_t SOBEL_X [9] = '{
        -8'sd1, 8'sd0, 8'sd1,
        -8'sd2, 8'sd0, 8'sd2,
        -8'sd1, 8'sd0, 8'sd1
    };
endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: the value read at the pointer is the one written WIDTH
// enabled cycles earlier; the same slot is then overwritten.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BITW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITW-1:0] wr_data,
    output logic [BITW-1:0] rd_data
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(WIDTH - 1);

    logic [BITW-1:0] mem_q [WIDTH];
    logic [AW-1:0]   ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[ptr_q];
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a WIDTH x HEIGHT raster frame, output |sum|
// saturated to BITW bits, border pixels forced to 0. Macro CONV_KERNEL_LOAD_EN adds a kernel write port.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int BITW   = 8,
    parameter int ACCW   = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITW-1:0] in_pix,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITW-1:0] out_pix,
    output logic            frame_done
`ifdef CONV_KERNEL_LOAD_EN
    ,
    input  logic            k_we,
    input  logic [3:0]      k_addr,
    input  coef_t           k_data
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic signed [ACCW-1:0] PIX_MAX = ACCW'((1 << BITW) - 1);

    function automatic logic [BITW-1:0] sat_abs(input logic signed [ACCW-1:0] s);
        logic signed [ACCW-1:0] mag;
        mag = s[ACCW-1] ? -s : s;
        return (mag > PIX_MAX) ? PIX_MAX[BITW-1:0] : mag[BITW-1:0];
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          in_col_q, in_col_d, gen_col_q, gen_col_d;
    logic [RW-1:0]          in_row_q, in_row_d, gen_row_q, gen_row_d;
    logic                   gen_done_q, gen_done_d;
    logic                   vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
    logic                   border_p0_q, border_p0_d;
    logic [BITW-1:0]        win_p0_q [3][3];
    logic [BITW-1:0]        win_p0_d [3][3];
    logic                   vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
    logic [BITW-1:0]        out_pix_q, out_pix_d;
    coef_t                  kern [3][3];
    logic signed [ACCW-1:0] acc_p0;
    logic [BITW-1:0]        lb1_rd, lb2_rd;
    logic adv, in_acc, in_last, fill_done, gen, gen_last, gen_border;

    // A held output freezes every stage, including input acceptance.
    assign adv        = !(vld_p1_q && !out_ready);
    assign in_ready   = adv && (state_q != FLUSH);
    assign in_acc     = in_valid && in_ready;
    assign in_last    = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
    assign fill_done  = (in_row_q == RW'(1)) && (in_col_q == CW'(1));
    assign gen        = (in_acc && (state_q == RUN || (state_q == FILL && fill_done)))
                     || (state_q == FLUSH && adv && !gen_done_q);
    assign gen_last   = (gen_row_q == ROW_LAST) && (gen_col_q == COL_LAST);
    assign gen_border = (gen_row_q == '0) || (gen_row_q == ROW_LAST)
                     || (gen_col_q == '0) || (gen_col_q == COL_LAST);

    assign out_valid  = vld_p1_q;
    assign out_pix    = out_pix_q;
    assign frame_done = vld_p1_q && out_ready && last_p1_q;

    conv_line_buffer #(.WIDTH(WIDTH), .BITW(BITW)) u_lb1 (
        .clk(clk), .rst(rst), .en(in_acc), .wr_data(in_pix), .rd_data(lb1_rd)
    );
    conv_line_buffer #(.WIDTH(WIDTH), .BITW(BITW)) u_lb2 (
        .clk(clk), .rst(rst), .en(in_acc), .wr_data(lb1_rd), .rd_data(lb2_rd)
    );

`ifdef CONV_KERNEL_LOAD_EN
    coef_t k_q [3][3];
    coef_t k_d [3][3];

    always_comb begin
        k_d = k_q;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (k_we && state_q == IDLE && k_addr == 4'(i * 3 + j)) begin
                    k_d[i][j] = k_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    k_q[i][j] <= SOBEL_X[i * 3 + j];
                end
            end
        end else begin
            k_q <= k_d;
        end
    end

    always_comb kern = k_q;
`else
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                kern[i][j] = SOBEL_X[i * 3 + j];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_acc) state_d = FILL;
            FILL:    if (in_acc && fill_done) state_d = RUN;
            RUN:     if (in_acc && in_last) state_d = FLUSH;
            FLUSH:   if (frame_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_p0 = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc_p0 = acc_p0 + ACCW'($signed({1'b0, win_p0_q[i][j]})) * ACCW'(kern[i][j]);
            end
        end
    end

    always_comb begin
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        gen_col_d   = gen_col_q;
        gen_row_d   = gen_row_q;
        gen_done_d  = gen_done_q;
        vld_p0_d    = vld_p0_q;
        last_p0_d   = last_p0_q;
        border_p0_d = border_p0_q;
        win_p0_d    = win_p0_q;
        vld_p1_d    = vld_p1_q;
        last_p1_d   = last_p1_q;
        out_pix_d   = out_pix_q;

        // Window column 2 gets rows r-2, r-1, r of the accepted column.
        if (in_acc) begin
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
            for (int i = 0; i < 3; i++) begin
                win_p0_d[i][0] = win_p0_q[i][1];
                win_p0_d[i][1] = win_p0_q[i][2];
            end
            win_p0_d[0][2] = lb2_rd;
            win_p0_d[1][2] = lb1_rd;
            win_p0_d[2][2] = in_pix;
        end

        if (gen) begin
            if (gen_col_q == COL_LAST) begin
                gen_col_d = '0;
                gen_row_d = (gen_row_q == ROW_LAST) ? '0 : gen_row_q + RW'(1);
            end else begin
                gen_col_d = gen_col_q + CW'(1);
            end
            if (gen_last) gen_done_d = 1'b1;
        end
        if (frame_done) gen_done_d = 1'b0;

        // p0 -> p1: convolve the captured window and saturate.
        if (adv) begin
            vld_p0_d    = gen;
            last_p0_d   = gen_last;
            border_p0_d = gen_border;
            vld_p1_d    = vld_p0_q;
            last_p1_d   = last_p0_q;
            if (vld_p0_q) begin
                out_pix_d = border_p0_q ? '0 : sat_abs(acc_p0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_col_q   <= '0;
            in_row_q   <= '0;
            gen_col_q  <= '0;
            gen_row_q  <= '0;
            gen_done_q <= 1'b0;
            vld_p0_q   <= 1'b0;
            last_p0_q  <= 1'b0;
            vld_p1_q   <= 1'b0;
            last_p1_q  <= 1'b0;
            out_pix_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            gen_col_q  <= gen_col_d;
            gen_row_q  <= gen_row_d;
            gen_done_q <= gen_done_d;
            vld_p0_q   <= vld_p0_d;
            last_p0_q  <= last_p0_d;
            vld_p1_q   <= vld_p1_d;
            last_p1_q  <= last_p1_d;
            out_pix_q  <= out_pix_d;
        end
    end

    always_ff @(posedge clk) begin
        win_p0_q    <= win_p0_d;
        border_p0_q <= border_p0_d;
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomized self-checking bench for conv3x3_stream against a frame-level convolution model.
module tb_conv3x3_stream;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int BW   = 8;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_pix = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_pix;
    logic          frame_done;
`ifdef CONV_KERNEL_LOAD_EN
    logic              k_we = 1'b0;
    logic [3:0]        k_addr = '0;
    logic signed [7:0] k_data = '0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int imgs [2][NPIX];
    int kern_m [3][3];
    int exp_q[$];
    int got[$];
    int acc_cyc[$];
    int out_cyc[$];
    int fd_cyc[$];
    int rmode = 0;
    int stall_left = 0;
    int stall_seen = 0;
    bit stall_done = 1'b0;
    bit mon_chk = 1'b0;

    conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .BITW(BW), .ACCW(20)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .frame_done(frame_done)
`ifdef CONV_KERNEL_LOAD_EN
        , .k_we(k_we), .k_addr(k_addr), .k_data(k_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, req);
        end
    endtask

    function automatic int model_pix(input int f, input int r, input int c);
        int s = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += kern_m[i][j] * imgs[f][(r - 1 + i) * W + (c - 1 + j)];
        if (s < 0) s = -s;
        return (s > 255) ? 255 : s;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (mon_chk && out_valid && !out_ready) begin
                stall_seen++;
                if (got.size() < exp_q.size()) check("stall_pix", int'(out_pix), exp_q[got.size()]);
                check("stall_in_ready", int'(in_ready), 0);
            end
            if (out_valid && out_ready) begin
                got.push_back(int'(out_pix));
                out_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(99) < 70);
                default: begin
                    if (!stall_done && got.size() >= 20) begin
                        stall_done = 1'b1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic send_range(input int f, input int count, input int gap_pct);
        for (int n = 0; n < count; n++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_pix   = BW'(imgs[f][n]);
            begin
                int waited = 0;
                while (1) begin
                    @(negedge clk);
                    if (in_ready) break;
                    waited++;
                    if (waited > 500) begin
                        check("in_timeout", 0, 1);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frames(input string tag, input int nfr, input int gap, input int rm);
        exp_q.delete(); got.delete(); acc_cyc.delete(); out_cyc.delete(); fd_cyc.delete();
        stall_done = 1'b0;
        stall_left = 0;
        stall_seen = 0;
        rmode = rm;
        for (int f = 0; f < nfr; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    exp_q.push_back(model_pix(f, r, c));
        mon_chk = 1'b1;
        for (int f = 0; f < nfr; f++) send_range(f, NPIX, gap);
        begin
            int waited = 0;
            while (got.size() < nfr * NPIX && waited < 3000) begin
                @(posedge clk);
                waited++;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        mon_chk = 1'b0;
        rmode = 0;
        check({tag, "_count"}, got.size(), nfr * NPIX);
        check({tag, "_frames"}, fd_cyc.size(), nfr);
        for (int m = 0; m < nfr * NPIX && m < got.size(); m++)
            check($sformatf("%s_px%0d", tag, m), got[m], exp_q[m]);
        for (int f = 0; f < nfr && f < fd_cyc.size(); f++)
            if ((f + 1) * NPIX - 1 < out_cyc.size())
                check($sformatf("%s_fdpos%0d", tag, f), fd_cyc[f], out_cyc[(f + 1) * NPIX - 1]);
        if (gap == 0 && rm == 0 && out_cyc.size() >= NPIX && acc_cyc.size() >= NPIX) begin
            for (int m = 0; m <= NPIX - W - 2; m++)
                check($sformatf("%s_lat%0d", tag, m), out_cyc[m] - acc_cyc[m + W + 1], 2);
            for (int m = NPIX - W - 1; m < NPIX; m++)
                check($sformatf("%s_flush%0d", tag, m), out_cyc[m] - out_cyc[m - 1], 1);
            check({tag, "_rate"}, acc_cyc[NPIX - 1] - acc_cyc[0], NPIX - 1);
            if (nfr > 1 && fd_cyc.size() > 0 && acc_cyc.size() > NPIX)
                check({tag, "_restart"}, acc_cyc[NPIX] - fd_cyc[0], 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        kern_m = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_out_pix", int'(out_pix), 0);
        @(posedge clk); #1;

        for (int n = 0; n < NPIX; n++) imgs[0][n] = 100;
        run_frames("const", 1, 0, 0);

        for (int n = 0; n < NPIX; n++) begin
            imgs[0][n] = 10 * (n % W);
            imgs[1][n] = 10 * (W - 1 - (n % W));
        end
        run_frames("ramp", 2, 0, 0);

        for (int n = 0; n < NPIX; n++) imgs[0][n] = ((n % W) < 4) ? 0 : 255;
        run_frames("step", 1, 0, 0);

        for (int n = 0; n < NPIX; n++) imgs[0][n] = $urandom_range(255);
        run_frames("stall", 1, 0, 2);
        check("stall_cycles", stall_seen, 5);

        for (int n = 0; n < NPIX; n++) begin
            imgs[0][n] = $urandom_range(255);
            imgs[1][n] = $urandom_range(255);
        end
        run_frames("rand", 2, 30, 1);

        for (int n = 0; n < NPIX; n++) imgs[0][n] = 50;
        send_range(0, 20, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        run_frames("rst50", 1, 0, 0);

`ifdef CONV_KERNEL_LOAD_EN
        for (int a = 0; a < 9; a++) begin
            k_we = 1'b1;
            k_addr = 4'(a);
            k_data = (a == 4) ? 8'sd1 : 8'sd0;
            @(posedge clk); #1;
        end
        k_addr = 4'd9;
        k_data = 8'sd7;
        @(posedge clk); #1;
        k_we = 1'b0;
        kern_m = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        for (int n = 0; n < NPIX; n++) imgs[0][n] = 10 * (n % W);
        fork
            run_frames("ident", 1, 0, 0);
            begin
                repeat (30) @(posedge clk);
                #1;
                k_we = 1'b1;
                k_addr = 4'd4;
                k_data = 8'sd3;
                @(posedge clk); #1;
                k_we = 1'b0;
            end
        join
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
